mercury_ps2_rx: RTL and testbench

//  Parametrised PS/2 device-to-host receiver with a buffered byte output. Cleans ps2_clk/ps2_data
//  (synchroniser + glitch filter), decodes 11-bit frames, validates start/stop bits and optionally

---
 rtl/mercury_ps2_pkg.sv | 20 ++
 rtl/mercury_sync_fifo.sv | 50 +++++
 rtl/mercury_ps2_rx.sv | 189 ++++++++++++++++++
 tb/tb_mercury_ps2_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mercury_ps2_pkg.sv
// Shared types and constants for the mercury PS/2 receiver: frame geometry,
// decoder state encoding and the odd-parity helper.
package mercury_ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/mercury_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy level; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module mercury_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (level == LVL_FULL);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? {WIDTH{1'b0}} : mem[rd_ptr[AW-1:0]];

  // Read/write pointers, one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mercury_ps2_rx.sv
// PS/2 device-to-host receiver: pin sync + glitch filter, 11-bit frame decoder with timeout,
// byte FIFO drained by valid/ready. Define PS2_RX_PARITY_CHK_EN to enforce odd parity.
module mercury_ps2_rx
  import mercury_ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 16,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               app_clk,
  input  logic               app_arst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy,
  output logic               err_frame,
  output logic               err_parity,
  output logic               err_overflow
);

  localparam int FCW = $clog2(FILT_LEN);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int BW  = $clog2(PS2_FRAME_BITS);
`ifdef PS2_RX_PARITY_CHK_EN
  localparam logic PAR_CHK = 1'b1;
`else
  localparam logic PAR_CHK = 1'b0;
`endif

  logic [1:0]               clk_sync, data_sync;
  logic                     clk_filt, data_filt, clk_filt_d, fall;
  logic [FCW-1:0]           clk_fcnt, data_fcnt;
  logic [TW-1:0]            tmo_cnt;
  logic                     timeout;
  ps2_state_e               state, state_nx;
  logic [BW-1:0]            bit_cnt, bit_cnt_nx;
  logic [PS2_DATA_BITS-1:0] shreg, shreg_nx;
  logic                     par_bit, par_nx, parity_ok;
  logic                     push, pop, fifo_full, fifo_empty;
  logic                     frame_err_nx, parity_err_nx;

  // Two-flop synchronisers; idle bus is high.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Clock glitch filter: flip only after FILT_LEN consecutive differing samples.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      clk_filt <= 1'b1;
      clk_fcnt <= {FCW{1'b0}};
    end else if (clk_sync[1] == clk_filt) begin
      clk_fcnt <= {FCW{1'b0}};
    end else if (clk_fcnt == FCW'(FILT_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      clk_fcnt <= {FCW{1'b0}};
    end else begin
      clk_fcnt <= clk_fcnt + FCW'(1);
    end
  end

  // Data glitch filter, same rule as the clock so both see equal delay.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      data_filt <= 1'b1;
      data_fcnt <= {FCW{1'b0}};
    end else if (data_sync[1] == data_filt) begin
      data_fcnt <= {FCW{1'b0}};
    end else if (data_fcnt == FCW'(FILT_LEN - 1)) begin
      data_filt <= data_sync[1];
      data_fcnt <= {FCW{1'b0}};
    end else begin
      data_fcnt <= data_fcnt + FCW'(1);
    end
  end

  // Registered falling-edge strobe and mid-frame inactivity counter.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      clk_filt_d <= 1'b1;
      fall       <= 1'b0;
      tmo_cnt    <= {TW{1'b0}};
    end else begin
      clk_filt_d <= clk_filt;
      fall       <= clk_filt_d & ~clk_filt;
      if (fall || state == IDLE) tmo_cnt <= {TW{1'b0}};
      else                       tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout   = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign parity_ok = !PAR_CHK || odd_parity_ok(shreg, par_bit);

  // Frame decoder next-state; a bad stop bit outranks a parity error.
  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    shreg_nx      = shreg;
    par_nx        = par_bit;
    push          = 1'b0;
    frame_err_nx  = 1'b0;
    parity_err_nx = 1'b0;
    if (timeout) begin
      state_nx     = IDLE;
      frame_err_nx = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (data_filt) begin
            frame_err_nx = 1'b1;
          end else begin
            state_nx   = DATA;
            bit_cnt_nx = {BW{1'b0}};
          end
        end
        DATA: begin
          shreg_nx   = {data_filt, shreg[PS2_DATA_BITS-1:1]};
          bit_cnt_nx = bit_cnt + BW'(1);
          if (bit_cnt == BW'(PS2_DATA_BITS - 1)) state_nx = PARITY;
          else                                   state_nx = DATA;
        end
        PARITY: begin
          par_nx   = data_filt;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (!data_filt)      frame_err_nx  = 1'b1;
          else if (!parity_ok) parity_err_nx = 1'b1;
          else                 push          = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end else begin
      state_nx = state;
    end
  end

  // Decoder state and registered error pulses.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      state        <= IDLE;
      bit_cnt      <= {BW{1'b0}};
      shreg        <= {PS2_DATA_BITS{1'b0}};
      par_bit      <= 1'b0;
      err_frame    <= 1'b0;
      err_parity   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nx;
      bit_cnt      <= bit_cnt_nx;
      shreg        <= shreg_nx;
      par_bit      <= par_nx;
      err_frame    <= frame_err_nx;
      err_parity   <= parity_err_nx;
      err_overflow <= push & fifo_full & ~pop;
    end
  end

  assign pop      = rx_valid & rx_ready;
  assign rx_valid = ~fifo_empty;
  assign busy     = (state != IDLE);

  mercury_sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (app_clk),
    .rst       (app_arst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_mercury_ps2_rx.sv
// Randomised self-checking bench for mercury_ps2_rx: frames are built from bytes, the
// expected byte stream and error pulses come from a queue-based model of the receiver.
module tb_mercury_ps2_rx;

  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int FIFO_DEPTH  = 16;
  localparam int HALF        = 20;
`ifdef PS2_RX_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic       app_clk  = 1'b0;
  logic       app_arst = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_level;
  logic       busy, err_frame, err_parity, err_overflow;

  int n_pass = 0, n_checks = 0;
  int cyc = 0;
  int frame_cnt = 0, par_cnt = 0, ovf_cnt = 0;
  int rise_cyc = -1, stop_fall_cyc = 0;
  int acc_total = 0, got_total = 0;
  int ready_mode = 0;
  logic valid_q = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 app_clk = ~app_clk;

  mercury_ps2_rx #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .app_clk      (app_clk),
    .app_arst     (app_arst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .fifo_level   (fifo_level),
    .busy         (busy),
    .err_frame    (err_frame),
    .err_parity   (err_parity),
    .err_overflow (err_overflow)
  );

  always @(posedge app_clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle: record accepted bytes, count error pulse cycles.
  always @(negedge app_clk) begin
    if (!app_arst) begin
      if (rx_valid && rx_ready) begin
        got_q.push_back(rx_data);
        got_total <= got_total + 1;
      end
      if (rx_valid && !valid_q) rise_cyc <= cyc;
      valid_q   <= rx_valid;
      frame_cnt <= frame_cnt + int'(err_frame);
      par_cnt   <= par_cnt + int'(err_parity);
      ovf_cnt   <= ovf_cnt + int'(err_overflow);
    end else begin
      valid_q <= 1'b0;
    end
  end

  // Consumer handshake: 0 = stalled, 1 = always ready, otherwise random.
  initial begin
    forever begin
      @(posedge app_clk);
      #2;
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge app_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit, input int nbits);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  // Model: decide the frame's fate from its bits and current model occupancy, then send it.
  task automatic frame_expect(input logic [7:0] b, input logic par_flip, input logic stop_bit, input string tag);
    int f0, p0, o0, ef, ep, eo;
    f0 = frame_cnt; p0 = par_cnt; o0 = ovf_cnt;
    ef = 0; ep = 0; eo = 0;
    if (!stop_bit)                             ef = 1;
    else if (par_flip && PAR_CHK)              ep = 1;
    else if (acc_total - got_total >= FIFO_DEPTH) eo = 1;
    else begin
      exp_q.push_back(b);
      acc_total++;
    end
    send_frame(b, par_flip, stop_bit, 11);
    check_eq({tag, ".err_frame"},    frame_cnt - f0, ef);
    check_eq({tag, ".err_parity"},   par_cnt - p0,   ep);
    check_eq({tag, ".err_overflow"}, ovf_cnt - o0,   eo);
  endtask

  task automatic check_stream(input string tag);
    int n;
    check_eq({tag, ".count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, ".byte"}, int'(got_q[i]), int'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int f0;
    logic [7:0] b;
    int kind;

    wait_cyc(4);
    check_eq("rst.rx_valid",   int'(rx_valid), 0);
    check_eq("rst.fifo_level", int'(fifo_level), 0);
    check_eq("rst.busy",       int'(busy), 0);
    check_eq("rst.rx_data",    int'(rx_data), 0);
    check_eq("rst.errs",       int'({err_frame, err_parity, err_overflow}), 0);
    app_arst = 1'b0;
    wait_cyc(5);

    // Single byte with exact pin-to-valid latency.
    ready_mode = 1;
    frame_expect(8'h1C, 1'b0, 1'b1, "b1c");
    check_eq("b1c.latency", rise_cyc - stop_fall_cyc, 2 + FILT_LEN + 2);
    check_stream("b1c");

    // Three buffered bytes, then drained in order.
    ready_mode = 0;
    wait_cyc(3);
    frame_expect(8'hF0, 1'b0, 1'b1, "q3");
    frame_expect(8'hAA, 1'b0, 1'b1, "q3");
    frame_expect(8'h55, 1'b0, 1'b1, "q3");
    check_eq("q3.level", int'(fifo_level), 3);
    check_eq("q3.head",  int'(rx_data), 8'hF0);
    ready_mode = 1;
    wait_cyc(20);
    check_eq("q3.level_drained", int'(fifo_level), 0);
    check_stream("q3");

    // Parity bit flipped, then bad stop bit.
    frame_expect(8'h1C, 1'b1, 1'b1, "par");
    frame_expect(8'h3A, 1'b0, 1'b0, "stop");
    check_stream("par_stop");

    // Frame abandoned after four data bits.
    f0 = frame_cnt;
    send_frame(8'h5A, 1'b0, 1'b1, 5);
    check_eq("tmo.busy_mid", int'(busy), 1);
    wait_cyc(TIMEOUT_CYC + 50);
    check_eq("tmo.err_frame", frame_cnt - f0, 1);
    check_eq("tmo.busy_after", int'(busy), 0);
    frame_expect(8'h77, 1'b0, 1'b1, "tmo_next");
    check_stream("tmo_next");

    // Fill the FIFO, then overflow it.
    ready_mode = 0;
    wait_cyc(3);
    for (int i = 0; i < FIFO_DEPTH; i++) frame_expect(8'($urandom), 1'b0, 1'b1, "fill");
    check_eq("fill.level", int'(fifo_level), FIFO_DEPTH);
    check_eq("fill.head",  int'(rx_data), int'(exp_q[0]));
    frame_expect(8'hE7, 1'b0, 1'b1, "ovf");
    check_eq("ovf.level", int'(fifo_level), FIFO_DEPTH);
    check_eq("ovf.head",  int'(rx_data), int'(exp_q[0]));
    ready_mode = 1;
    wait_cyc(40);
    check_eq("ovf.level_drained", int'(fifo_level), 0);
    check_stream("ovf");

    // Short clock glitch while idle must be filtered out.
    f0 = frame_cnt;
    ps2_clk = 1'b0;
    wait_cyc(FILT_LEN - 1);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check_eq("glitch.busy", int'(busy), 0);
    check_eq("glitch.err_frame", frame_cnt - f0, 0);

    // Reset mid-frame with one byte buffered.
    ready_mode = 0;
    wait_cyc(3);
    frame_expect(8'h42, 1'b0, 1'b1, "arst_pre");
    send_frame(8'h99, 1'b0, 1'b1, 4);
    check_eq("arst.busy_mid", int'(busy), 1);
    f0 = frame_cnt;
    app_arst = 1'b1;
    wait_cyc(3);
    check_eq("arst.busy",  int'(busy), 0);
    check_eq("arst.level", int'(fifo_level), 0);
    app_arst = 1'b0;
    exp_q.delete();
    got_q.delete();
    acc_total = got_total;
    wait_cyc(5);
    check_eq("arst.err_frame", frame_cnt - f0, 0);
    ready_mode = 1;
    frame_expect(8'h24, 1'b0, 1'b1, "arst_next");
    check_stream("arst_next");

    // Random bytes, random faults, random consumer.
    ready_mode = 2;
    for (int i = 0; i < 20; i++) begin
      b    = 8'($urandom);
      kind = int'($urandom_range(0, 9));
      frame_expect(b, kind == 1, kind != 0, "rnd");
    end
    ready_mode = 1;
    wait_cyc(30);
    check_eq("rnd.level", int'(fifo_level), 0);
    check_stream("rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
